// File: rtl/snn_inference_sequencer.sv
// Inference-window sequencer for the 4-4-2 spiking steering network.
// On start it latches the sensors and holds the network in reset, then runs it
// for a fixed window while counting output spikes. It finishes with a
// registered left/right decision followed by a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start; net_rst pulses here for one cycle after an abort
// CLEAR  | network held in reset for CLR_CYC cycles
// RUN    | network enabled for WINDOW cycles, output spikes counted
// DECIDE | counts and steer already visible on the outputs
// DONE   | done pulse, then back to IDLE
module snn_inference_sequencer #(
  parameter int WINDOW  = 64,
  parameter int CLR_CYC = 2,
  parameter int CW      = 8,
  parameter int SW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [SW-1:0] sensor_fl,
  input  logic [SW-1:0] sensor_ml,
  input  logic [SW-1:0] sensor_mr,
  input  logic [SW-1:0] sensor_fr,
  input  logic [1:0]    out_spike,
  output logic          net_rst,
  output logic          net_en,
  output logic [SW-1:0] sensor_q_fl,
  output logic [SW-1:0] sensor_q_ml,
  output logic [SW-1:0] sensor_q_mr,
  output logic [SW-1:0] sensor_q_fr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt_left,
  output logic [CW-1:0] cnt_right,
  output logic [1:0]    steer
);

  localparam int CMAX = (WINDOW > CLR_CYC) ? WINDOW : CLR_CYC;
  localparam int CYW  = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CYW-1:0] cyc_q, cyc_d;
  logic [CW-1:0]  spk_l_q, spk_l_d, spk_r_q, spk_r_d;
  logic [CW-1:0]  spk_l_nx, spk_r_nx;
  logic [SW-1:0]  sens_fl_q, sens_fl_d, sens_ml_q, sens_ml_d;
  logic [SW-1:0]  sens_mr_q, sens_mr_d, sens_fr_q, sens_fr_d;
  logic [CW-1:0]  cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic [1:0]     steer_q, steer_d;
  logic           net_rst_q, net_rst_d, net_en_q, net_en_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           abort_rst;

  // Next-state, counter and output computation. Outputs are derived from the
  // next state so they appear in the same cycle the state does; the last RUN
  // cycle's spike is folded into the result copied on entry to DECIDE.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    spk_l_d   = spk_l_q;
    spk_r_d   = spk_r_q;
    sens_fl_d = sens_fl_q;
    sens_ml_d = sens_ml_q;
    sens_mr_d = sens_mr_q;
    sens_fr_d = sens_fr_q;
    cnt_l_d   = cnt_l_q;
    cnt_r_d   = cnt_r_q;
    steer_d   = steer_q;
    abort_rst = 1'b0;
    spk_l_nx  = (out_spike[0] && (spk_l_q != {CW{1'b1}})) ? spk_l_q + CW'(1) : spk_l_q;
    spk_r_nx  = (out_spike[1] && (spk_r_q != {CW{1'b1}})) ? spk_r_q + CW'(1) : spk_r_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sens_fl_d = sensor_fl;
          sens_ml_d = sensor_ml;
          sens_mr_d = sensor_mr;
          sens_fr_d = sensor_fr;
          spk_l_d   = '0;
          spk_r_d   = '0;
          cyc_d     = CYW'(CLR_CYC - 1);
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d   = S_IDLE;
          abort_rst = 1'b1;
        end else if (cyc_q == '0) begin
          cyc_d   = CYW'(WINDOW - 1);
          state_d = S_RUN;
        end else begin
          cyc_d = cyc_q - CYW'(1);
        end
      end
      S_RUN: begin
        spk_l_d = spk_l_nx;
        spk_r_d = spk_r_nx;
        if (abort) begin
          state_d   = S_IDLE;
          abort_rst = 1'b1;
        end else if (cyc_q == '0) begin
          state_d = S_DECIDE;
          cnt_l_d = spk_l_nx;
          cnt_r_d = spk_r_nx;
          if (spk_l_nx > spk_r_nx)      steer_d = 2'b01;
          else if (spk_r_nx > spk_l_nx) steer_d = 2'b10;
          else                          steer_d = 2'b00;
        end else begin
          cyc_d = cyc_q - CYW'(1);
        end
      end
      S_DECIDE: begin
        if (abort) begin
          state_d   = S_IDLE;
          abort_rst = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    net_rst_d = abort_rst || (state_d == S_CLEAR);
    net_en_d  = (state_d == S_RUN);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      spk_l_q   <= '0;
      spk_r_q   <= '0;
      sens_fl_q <= '0;
      sens_ml_q <= '0;
      sens_mr_q <= '0;
      sens_fr_q <= '0;
      cnt_l_q   <= '0;
      cnt_r_q   <= '0;
      steer_q   <= '0;
      net_rst_q <= 1'b0;
      net_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      spk_l_q   <= spk_l_d;
      spk_r_q   <= spk_r_d;
      sens_fl_q <= sens_fl_d;
      sens_ml_q <= sens_ml_d;
      sens_mr_q <= sens_mr_d;
      sens_fr_q <= sens_fr_d;
      cnt_l_q   <= cnt_l_d;
      cnt_r_q   <= cnt_r_d;
      steer_q   <= steer_d;
      net_rst_q <= net_rst_d;
      net_en_q  <= net_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign net_rst     = net_rst_q;
  assign net_en      = net_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cnt_left    = cnt_l_q;
  assign cnt_right   = cnt_r_q;
  assign steer       = steer_q;
  assign sensor_q_fl = sens_fl_q;
  assign sensor_q_ml = sens_ml_q;
  assign sensor_q_mr = sens_mr_q;
  assign sensor_q_fr = sens_fr_q;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Directed bench for snn_inference_sequencer with WINDOW=8, CLR_CYC=2, CW=3.
// Cycle t counts periods after the edge that samples start: net_rst t=1..2,
// net_en t=3..10, results visible t=11, done t=12, idle again at t=13.
module tb_snn_inference_sequencer;

  localparam int WINDOW  = 8;
  localparam int CLR_CYC = 2;
  localparam int CW      = 3;
  localparam int SW      = 12;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [SW-1:0] sensor_fl, sensor_ml, sensor_mr, sensor_fr;
  logic [1:0]    out_spike;
  logic          net_rst, net_en, busy, done;
  logic [SW-1:0] sensor_q_fl, sensor_q_ml, sensor_q_mr, sensor_q_fr;
  logic [CW-1:0] cnt_left, cnt_right;
  logic [1:0]    steer;

  int n_vec = 0;
  int n_err = 0;

  logic [CW-1:0] prev_l, prev_r;
  logic [1:0]    prev_s;

  typedef struct {
    logic [7:0]    lp;       // left spike per RUN cycle, bit i = RUN cycle i
    logic [7:0]    rp;
    logic          noise;    // spikes held high outside RUN
    logic          restart;  // start re-asserted mid-run
    logic          ab;       // abort with start in IDLE and again in DONE
    logic [CW-1:0] el;
    logic [CW-1:0] er;
    logic [1:0]    es;
  } vec_t;

  vec_t vecs[6];

  snn_inference_sequencer #(
    .WINDOW(WINDOW), .CLR_CYC(CLR_CYC), .CW(CW), .SW(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sensor_fl(sensor_fl), .sensor_ml(sensor_ml),
    .sensor_mr(sensor_mr), .sensor_fr(sensor_fr),
    .out_spike(out_spike),
    .net_rst(net_rst), .net_en(net_en),
    .sensor_q_fl(sensor_q_fl), .sensor_q_ml(sensor_q_ml),
    .sensor_q_mr(sensor_q_mr), .sensor_q_fr(sensor_q_fr),
    .busy(busy), .done(done),
    .cnt_left(cnt_left), .cnt_right(cnt_right), .steer(steer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int t, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  function automatic logic [3:0] ctrl_exp(input int t);
    ctrl_exp = {(t >= 1 && t <= CLR_CYC),
                (t >= CLR_CYC + 1 && t <= CLR_CYC + WINDOW),
                (t >= 1 && t <= CLR_CYC + WINDOW + 2),
                (t == CLR_CYC + WINDOW + 2)};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [SW-1:0] s0, s1, s2, s3;
    s0 = 12'h100 + 12'(idx);
    s1 = 12'h2A0 ^ 12'(idx * 7);
    s2 = 12'hC35 + 12'(idx * 13);
    s3 = 12'hFFF - 12'(idx);
    chk("entry_idle", 0, {60'd0, net_rst, net_en, busy, done}, 64'd0);
    sensor_fl = s0; sensor_ml = s1; sensor_mr = s2; sensor_fr = s3;
    start = 1'b1;
    abort = v.ab;
    out_spike = v.noise ? 2'b11 : 2'b00;
    for (int t = 1; t <= 13; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        start = 1'b0;
        sensor_fl = ~s0; sensor_ml = ~s1; sensor_mr = ~s2; sensor_fr = ~s3;
      end
      if (v.restart) start = (t >= 4 && t <= 8);
      abort = v.ab && (t == 12);
      if (t >= 3 && t <= 10) out_spike = {v.rp[t-3], v.lp[t-3]};
      else if (t <= 12)      out_spike = v.noise ? 2'b11 : 2'b00;
      else                   out_spike = 2'b00;
      chk("ctrl", t, {60'd0, net_rst, net_en, busy, done}, {60'd0, ctrl_exp(t)});
      if (t == 1)
        chk("held_result", t, {56'd0, cnt_left, cnt_right, steer}, {56'd0, prev_l, prev_r, prev_s});
      if (t == 11) begin
        chk("result", t, {56'd0, cnt_left, cnt_right, steer}, {56'd0, v.el, v.er, v.es});
        prev_l = v.el; prev_r = v.er; prev_s = v.es;
      end
      if (t == 12)
        chk("sensor_hold", t, {16'd0, sensor_q_fl, sensor_q_ml, sensor_q_mr, sensor_q_fr},
            {16'd0, s0, s1, s2, s3});
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    //            lp      rp     noise restart ab    el    er    es
    vecs[0] = '{8'h1F, 8'h81, 1'b0, 1'b0, 1'b0, 3'd5, 3'd2, 2'b01};
    vecs[1] = '{8'h54, 8'h07, 1'b1, 1'b0, 1'b0, 3'd3, 3'd3, 2'b00};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd7, 3'd7, 2'b00};
    vecs[4] = '{8'h01, 8'h0F, 1'b0, 1'b0, 1'b1, 3'd1, 3'd4, 2'b10};
    vecs[5] = '{8'hFF, 8'h3F, 1'b1, 1'b0, 1'b0, 3'd7, 3'd6, 2'b01};

    rst = 1'b1; start = 1'b1; abort = 1'b1; out_spike = 2'b11;
    sensor_fl = 12'hABC; sensor_ml = 12'h123; sensor_mr = 12'h456; sensor_fr = 12'h789;
    prev_l = '0; prev_r = '0; prev_s = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 0, {50'd0, net_rst, net_en, busy, done, steer, cnt_left, cnt_right},
        64'd0);
    chk("reset_sensors", 0, {16'd0, sensor_q_fl, sensor_q_ml, sensor_q_mr, sensor_q_fr}, 64'd0);
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_spike = 2'b00;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort on the fourth RUN cycle: one-cycle net_rst, no done, result kept.
    sensor_fl = 12'h055; sensor_ml = 12'h0AA; sensor_mr = 12'h5A5; sensor_fr = 12'hA5A;
    start = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      out_spike = 2'b11;
      chk("abort_pre", t, {60'd0, net_rst, net_en, busy, done}, {60'd0, ctrl_exp(t)});
      if (t == 6) abort = 1'b1;
    end
    @(posedge clk); #1;
    abort = 1'b0;
    out_spike = 2'b00;
    chk("abort_rst_pulse", 7, {60'd0, net_rst, net_en, busy, done}, 64'b1000);
    for (int t = 8; t <= 12; t++) begin
      @(posedge clk); #1;
      chk("abort_idle", t, {60'd0, net_rst, net_en, busy, done}, 64'd0);
      chk("abort_result_kept", t, {56'd0, cnt_left, cnt_right, steer},
          {56'd0, prev_l, prev_r, prev_s});
    end
    run_vec(vecs[0], 7);

    // Synchronous reset in the middle of RUN.
    sensor_fl = 12'h321; sensor_ml = 12'h654; sensor_mr = 12'h987; sensor_fr = 12'hCBA;
    start = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      out_spike = 2'b01;
      if (t == 5) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_spike = 2'b00;
    chk("midrun_reset", 6, {50'd0, net_rst, net_en, busy, done, steer, cnt_left, cnt_right},
        64'd0);
    chk("midrun_reset_sensors", 6,
        {16'd0, sensor_q_fl, sensor_q_ml, sensor_q_mr, sensor_q_fr}, 64'd0);
    prev_l = '0; prev_r = '0; prev_s = '0;
    run_vec(vecs[4], 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
